// File: rtl/buffet_pkg.sv
// Shared constants and helpers for the buffet slot-tracking blocks.
// Width helpers keep every user of a WIDTH-slot table consistent.
package buffet_pkg;

  // Index width for a table of w slots; never narrower than one bit.
  function automatic int unsigned idx_width(input int unsigned w);
    return (w <= 1) ? 1 : $clog2(w);
  endfunction

  // Width needed to count 0..w occupied slots.
  function automatic int unsigned cnt_width(input int unsigned w);
    return $clog2(w + 1);
  endfunction

  // Reserved encoding should err ever be widened to report the cause.
  typedef enum logic [0:0] {
    ErrDoubleFree = 1'b0,
    ErrRange      = 1'b1
  } err_code_e;

endpackage

// File: rtl/slot_allocator_priority_encoder.sv
// Free-slot selector: returns the highest index whose occupancy bit is 0.
// With every bit set the result is 0 and must be gated by the caller.
module priorityEncoder
  import buffet_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  localparam int unsigned IDW = idx_width(WIDTH)
) (
  input  logic [WIDTH-1:0] occ,
  output logic [IDW-1:0]   idx
);

  always_comb begin
    idx = '0;
    // Ascending scan so the highest free index is written last.
    for (int i = 0; i < int'(WIDTH); i++) begin
      if (!occ[i]) begin
        idx = IDW'(i);
      end
    end
  end

endmodule

// File: rtl/slot_allocator.sv
// Occupancy tracker handing out free slot indices through a req/gnt handshake
// and accepting releases; keeps count, full/empty and a sticky protocol error.
module slot_allocator
  import buffet_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  localparam int unsigned IDW = idx_width(WIDTH),
  localparam int unsigned CW  = cnt_width(WIDTH)
) (
  input  logic             clk,
  input  logic             nreset,
  input  logic             flush,
  input  logic             alloc_req,
  output logic             alloc_gnt,
  output logic [IDW-1:0]   alloc_id,
  input  logic             free_valid,
  input  logic [IDW-1:0]   free_id,
  output logic [WIDTH-1:0] occ,
  output logic [CW-1:0]    count,
  output logic             full,
  output logic             empty,
  output logic             err
);

  logic [WIDTH-1:0] occ_q, occ_d;
  logic [CW-1:0]    count_q, count_d;
  logic             full_q, full_d;
  logic             empty_q, empty_d;
  logic             err_q, err_d;

  logic [IDW-1:0]   enc_idx;
  logic             free_in_range;
  logic             free_legal;
  logic             free_bad;
  logic [WIDTH-1:0] set_mask;
  logic [WIDTH-1:0] clr_mask;

  priorityEncoder #(
    .WIDTH (WIDTH)
  ) u_enc (
    .occ (occ_q),
    .idx (enc_idx)
  );

  // Grant depends only on registered state plus req/flush, never on free_valid.
  assign alloc_gnt = alloc_req & ~full_q & ~flush;
  assign alloc_id  = enc_idx;

  always_comb begin
    free_in_range = (32'(free_id) < WIDTH);
    free_legal    = free_valid & free_in_range & occ_q[free_id];
    free_bad      = free_valid & ~free_legal & ~flush;
    set_mask      = alloc_gnt  ? (WIDTH'(1) << alloc_id) : '0;
    clr_mask      = free_legal ? (WIDTH'(1) << free_id)  : '0;

    occ_d   = occ_q;
    count_d = count_q;
    err_d   = err_q | free_bad;

    if (flush) begin
      occ_d   = '0;
      count_d = '0;
    end else begin
      occ_d   = (occ_q | set_mask) & ~clr_mask;
      count_d = count_q + CW'(alloc_gnt) - CW'(free_legal);
    end

    full_d  = (count_d == CW'(WIDTH));
    empty_d = (count_d == '0);
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      occ_q   <= '0;
      count_q <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
      err_q   <= 1'b0;
    end else begin
      occ_q   <= occ_d;
      count_q <= count_d;
      full_q  <= full_d;
      empty_q <= empty_d;
      err_q   <= err_d;
    end
  end

  assign occ   = occ_q;
  assign count = count_q;
  assign full  = full_q;
  assign empty = empty_q;
  assign err   = err_q;

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (nreset) begin
      assert (int'($countones(occ_q)) == int'(count_q));
      assert (full_q == (count_q == CW'(WIDTH)));
      assert (empty_q == (count_q == '0));
    end
  end
`endif

endmodule

// File: tb/tb_slot_allocator.sv
// Randomised plus directed bench for slot_allocator against a slot-list model;
// a driver queues expected responses and a monitor compares them per cycle.
module tb_slot_allocator;

  localparam int WIDTH = 8;
  localparam int IDW   = 3;
  localparam int CW    = 4;

  logic             clk;
  logic             nreset;
  logic             flush;
  logic             alloc_req;
  logic             alloc_gnt;
  logic [IDW-1:0]   alloc_id;
  logic             free_valid;
  logic [IDW-1:0]   free_id;
  logic [WIDTH-1:0] occ;
  logic [CW-1:0]    count;
  logic             full;
  logic             empty;
  logic             err;

  slot_allocator #(
    .WIDTH (WIDTH)
  ) dut (
    .clk        (clk),
    .nreset     (nreset),
    .flush      (flush),
    .alloc_req  (alloc_req),
    .alloc_gnt  (alloc_gnt),
    .alloc_id   (alloc_id),
    .free_valid (free_valid),
    .free_id    (free_id),
    .occ        (occ),
    .count      (count),
    .full       (full),
    .empty      (empty),
    .err        (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit       gnt;
    int       id;
    bit [7:0] occ;
    int       cnt;
    bit       full;
    bit       empty;
    bit       err;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model: a plain per-slot "in use" list plus the sticky error.
  bit used[WIDTH];
  bit m_err;

  function automatic int used_count();
    int n = 0;
    for (int i = 0; i < WIDTH; i++) n += used[i];
    return n;
  endfunction

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < WIDTH; i++) used[i] = 1'b0;
    m_err = 1'b0;
  endtask

  // Drive one cycle of stimulus and queue what the DUT must show for it.
  task automatic step(input bit req, input bit fv, input int fid, input bit fl);
    exp_t e;
    bit   legal;
    @(negedge clk);
    alloc_req  = req;
    free_valid = fv;
    free_id    = IDW'(fid);
    flush      = fl;
    e.gnt = req && (used_count() != WIDTH) && !fl;
    e.id  = 0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (!used[i]) begin
        e.id = i;
        break;
      end
    end
    legal = fv && (fid < WIDTH) && used[fid];
    if (fl) begin
      for (int i = 0; i < WIDTH; i++) used[i] = 1'b0;
    end else begin
      if (e.gnt) used[e.id] = 1'b1;
      if (legal) used[fid] = 1'b0;
      if (fv && !legal) m_err = 1'b1;
    end
    e.occ = '0;
    for (int i = 0; i < WIDTH; i++) e.occ[i] = used[i];
    e.cnt   = used_count();
    e.full  = (e.cnt == WIDTH);
    e.empty = (e.cnt == 0);
    e.err   = m_err;
    exp_q.push_back(e);
  endtask

  task automatic idle();
    @(negedge clk);
    alloc_req  = 1'b0;
    free_valid = 1'b0;
    free_id    = '0;
    flush      = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 20) begin
      @(posedge clk);
      n++;
    end
    #2;
    check("drain_timeout", exp_q.size(), 0);
  endtask

  // Monitor: combinational outputs just before the edge, state just after.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #3;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("alloc_gnt", int'(alloc_gnt), int'(e.gnt));
        if (e.gnt) check("alloc_id", int'(alloc_id), e.id);
        @(posedge clk);
        #1;
        check("occ", int'(occ), int'(e.occ));
        check("count", int'(count), e.cnt);
        check("full", int'(full), int'(e.full));
        check("empty", int'(empty), int'(e.empty));
        check("err", int'(err), int'(e.err));
      end
    end
  end

  initial begin
    nreset     = 1'b0;
    flush      = 1'b0;
    alloc_req  = 1'b0;
    free_valid = 1'b0;
    free_id    = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #2;
    check("rst_occ", int'(occ), 0);
    check("rst_count", int'(count), 0);
    check("rst_full", int'(full), 0);
    check("rst_empty", int'(empty), 1);
    check("rst_err", int'(err), 0);
    @(negedge clk);
    nreset = 1'b1;

    // Fill: ids 7..0, then a refused ninth request.
    for (int k = 0; k < WIDTH; k++) step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    // Free from full, then re-grant slot 3.
    step(0, 1, 3, 0);
    step(1, 0, 0, 0);
    // Reach 0x0F, then simultaneous alloc and free of slot 2.
    for (int k = 7; k >= 4; k--) step(0, 1, k, 0);
    step(1, 1, 2, 0);
    // Double free of slot 5, then legal traffic keeps err set.
    step(0, 1, 5, 0);
    step(1, 0, 0, 0);
    step(0, 1, 7, 0);
    // Fill, flush with req and free, then first grant after flush.
    for (int k = 0; k < 5; k++) step(1, 0, 0, 0);
    step(1, 1, 0, 1);
    step(1, 0, 0, 0);
    // Free while empty.
    step(0, 0, 0, 1);
    step(0, 1, 4, 0);
    idle();
    drain();

    // Random traffic, biased toward freeing slots that are in use.
    for (int k = 0; k < 600; k++) begin
      int fid;
      fid = int'($urandom_range(0, WIDTH - 1));
      if ($urandom_range(0, 3) != 0) begin
        for (int j = 0; j < WIDTH; j++) begin
          if (used[(fid + j) % WIDTH]) begin
            fid = (fid + j) % WIDTH;
            break;
          end
        end
      end
      step($urandom_range(0, 9) < 6, $urandom_range(0, 9) < 4, fid,
           $urandom_range(0, 99) < 3);
    end
    idle();
    drain();

    // Asynchronous reset mid-cycle with occ = 0x3C and err set.
    @(negedge clk);
    nreset = 1'b0;
    #2;
    nreset = 1'b1;
    model_reset();
    for (int k = 0; k < 6; k++) step(1, 0, 0, 0);
    step(0, 1, 7, 0);
    step(0, 1, 6, 0);
    step(0, 1, 6, 0);
    idle();
    drain();
    check("pre_async_occ", int'(occ), 'h3C);
    check("pre_async_err", int'(err), 1);
    @(negedge clk);
    #2;
    nreset = 1'b0;
    #1;
    check("async_occ", int'(occ), 0);
    check("async_count", int'(count), 0);
    check("async_empty", int'(empty), 1);
    check("async_err", int'(err), 0);
    @(negedge clk);
    nreset = 1'b1;
    model_reset();
    step(1, 0, 0, 0);
    idle();
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/slot_allocator.md
Name: slot_allocator

Overview:
- Tracks occupancy of WIDTH storage slots (buffet / tag-table entries) and hands out free slot indices to one requester via a request/grant handshake.
- Accepts slot releases from the consumer side.
- Selects the next free slot with the existing priorityEncoder (highest-index free slot wins).
- Maintains occupancy count, full/empty flags and a sticky protocol-error flag.

Parameters:
- WIDTH, 8, number of slots; must be >= 2.
- IDW, $clog2(WIDTH), slot index width (localparam).
- CW, $clog2(WIDTH+1), occupancy count width (localparam).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- nreset  in  1  asynchronous active-low reset.
- flush  in  1  synchronous clear of all occupancy.
- alloc_req  in  1  requester wants a slot this cycle.
- alloc_gnt  out  1  slot granted this cycle (combinational).
- alloc_id  out  IDW  granted slot index; valid only when alloc_gnt=1.
- free_valid  in  1  release of slot free_id this cycle.
- free_id  in  IDW  slot index being released.
- occ  out  WIDTH  occupancy bitmap; bit i=1 means slot i is in use (registered).
- count  out  CW  number of occupied slots (registered).
- full  out  1  count==WIDTH (registered).
- empty  out  1  count==0 (registered).
- err  out  1  sticky protocol error (registered).

Behaviour:
- Reset (nreset=0, asynchronous): occ=0, count=0, full=0, empty=1, err=0.
- Selection:
  - Priority encoder input is the registered occ; it returns the highest index i with occ[i]=0.
  - With occ all ones the encoder output is 0, so it is meaningless; grant is gated by full.
- Grant rule: alloc_gnt = alloc_req & ~full & ~flush. alloc_id = encoder output, same cycle (zero-latency combinational).
- Grant commit: on the edge after alloc_gnt=1, occ[alloc_id] is set to 1.
- Free commit: on the edge after free_valid=1 with a legal free_id, occ[free_id] is cleared.
- Legal free: free_id < WIDTH and occ[free_id]=1.
- Illegal free (double free, or index >= WIDTH):
  - Sets err; occ and count are unchanged by that free.
  - A simultaneous grant still commits.
  - err clears only on reset.
- Simultaneous alloc and free in the same cycle:
  - Both commit.
  - The slot being freed is not visible to the encoder until the next cycle, so no same-cycle reuse.
  - A slot cannot be both granted and freed in one cycle: granted slots are free, and freeing a free slot is illegal.
  - count is unchanged when both commit, +1 for grant only, -1 for legal free only.
- Full boundary:
  - When full=1, alloc_gnt=0 regardless of alloc_req.
  - A legal free while full makes the slot grantable on the following cycle.
- Empty boundary: a free while empty is always illegal and sets err.
- Flush:
  - Next edge: occ=0, count=0, empty=1, full=0.
  - flush overrides same-cycle free.
  - Grant is suppressed during flush; err is preserved.
- Flags: full and empty are registered, computed from next-state count. No combinational path from free_valid to alloc_gnt.
- Reset mid-operation: all state clears immediately and alloc_gnt drops with full/flush semantics. Requesters must re-request after reset.
- No state machine beyond the occupancy register. count is kept as a register, not a popcount, and must always equal popcount(occ); this is asserted in simulation.

Decomposition:
- Shared package (buffet_pkg):
  - Slot-index width function/constant derived from WIDTH.
  - Error-code constant for double-free vs out-of-range, if err is later widened.
- One sub-module: the existing priorityEncoder #(.WIDTH(WIDTH)), instantiated on occ.
- Next-state occ/count logic stays in slot_allocator.

Test Plan (WIDTH=8):
1. Reset, then alloc_req=1 for 8 cycles -> alloc_id 7,6,5,4,3,2,1,0 in successive cycles; after the 8th edge full=1, count=8, occ=8'hFF; 9th-cycle alloc_gnt=0.
2. From full, free_valid with free_id=3 -> next cycle occ=8'hF7, count=7, full=0. alloc_req then -> alloc_gnt=1, alloc_id=3.
3. occ=8'h0F, same cycle alloc_req=1 and free_valid with free_id=2 -> alloc_id=7. Next: occ=8'h8B, count unchanged at 4; slot 2 is not granted in the free cycle.
4. Double free of slot 5 while occ[5]=0 -> err=1 next cycle, occ/count unchanged. err stays 1 through later legal traffic until nreset.
5. occ=8'hFF, assert flush with alloc_req=1 and free_valid -> alloc_gnt=0. Next: occ=0, count=0, empty=1, err preserved. Next alloc -> id 7.
6. Assert nreset=0 asynchronously mid-cycle with occ=8'h3C -> occ=0, empty=1, err=0 immediately, without waiting for clk.
